// File: rtl/uart_pkg.sv
// Shared register map, STAT bit positions and read-side state type for the uartlite glue.
package uart_pkg;

    localparam logic [3:0] REG_RX_FIFO = 4'h0;
    localparam logic [3:0] REG_TX_FIFO = 4'h4;
    localparam logic [3:0] REG_STAT    = 4'h8;
    localparam logic [3:0] REG_CTRL    = 4'hC;

    localparam int RX_VALID   = 0;
    localparam int OVERRUN    = 5;
    localparam int FRAME_ERR  = 6;
    localparam int PARITY_ERR = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        STAT_AR,
        STAT_R,
        RX_AR,
        RX_R,
        HOLD,
        GAP
    } rd_state_t;

endpackage

// File: rtl/uart_rx_reader.sv
// AXI4-Lite read initiator: polls uartlite STAT, pops RX bytes and streams them out
// on a valid/ready interface, collecting sticky line/bus error flags on the way.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | polling disabled, no read in flight
//  STAT_AR | read address for STAT presented, waiting for arready
//  STAT_R  | waiting for STAT read data
//  RX_AR   | read address for RX_FIFO presented, waiting for arready
//  RX_R    | waiting for RX_FIFO read data
//  HOLD    | byte presented on data/valid, waiting for ready
//  GAP     | back-off between an empty (or failed) poll and the next one
module uart_rx_reader
    import uart_pkg::*;
#(
    parameter int POLL_GAP = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [7:0]        data,
    output logic              valid,
    input  logic              ready,
    output logic              err_overrun,
    output logic              err_frame,
    output logic              err_parity,
    output logic              err_resp,
    input  logic              err_clr
);

    localparam int              CNT_W  = $clog2(POLL_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(POLL_GAP - 1);

    rd_state_t        state;
    rd_state_t        next_state;
    logic [CNT_W-1:0] gap_cnt;
    logic             ar_done;
    logic             resp_ok;
    logic             stat_ok;
    logic             rx_ok;
    logic             resp_bad;
    logic             unused_rdata;

    assign ar_done  = m_arvalid && m_arready;
    assign resp_ok  = (m_rresp == RESP_OKAY);
    assign stat_ok  = (state == STAT_R) && m_rvalid && resp_ok;
    assign rx_ok    = (state == RX_R) && m_rvalid && resp_ok;
    assign resp_bad = m_rready && m_rvalid && !resp_ok;

    // Only the low byte of any read carries information for this block.
    assign unused_rdata = ^m_rdata[31:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (enable) next_state = STAT_AR;
            end
            STAT_AR: begin
                if (ar_done) next_state = STAT_R;
            end
            STAT_R: begin
                if (m_rvalid) begin
                    if (resp_ok && m_rdata[RX_VALID]) next_state = RX_AR;
                    else                              next_state = GAP;
                end
            end
            RX_AR: begin
                if (ar_done) next_state = RX_R;
            end
            RX_R: begin
                if (m_rvalid) next_state = resp_ok ? HOLD : GAP;
            end
            HOLD: begin
                if (ready) next_state = enable ? STAT_AR : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_TC) next_state = enable ? STAT_AR : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Only one read can be outstanding: R is accepted solely while waiting for it.
    always_comb begin
        m_rready = (state == STAT_R) || (state == RX_R);
    end

    // AR outputs are registered from next_state so they line up with the *_AR states
    // and cannot glitch while a handshake is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_araddr  <= ADDR_W'(REG_STAT);
        end else begin
            m_arvalid <= (next_state == STAT_AR) || (next_state == RX_AR);
            m_araddr  <= (next_state == RX_AR) ? ADDR_W'(REG_RX_FIFO) : ADDR_W'(REG_STAT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else if (rx_ok) begin
            data  <= m_rdata[7:0];
            valid <= 1'b1;
        end else if ((state == HOLD) && ready) begin
            valid <= 1'b0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            err_overrun <= (stat_ok && m_rdata[OVERRUN])    || (err_overrun && !err_clr);
            err_frame   <= (stat_ok && m_rdata[FRAME_ERR])  || (err_frame   && !err_clr);
            err_parity  <= (stat_ok && m_rdata[PARITY_ERR]) || (err_parity  && !err_clr);
            err_resp    <= resp_bad                         || (err_resp    && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Bench for uart_rx_reader: AXI-Lite slave stub, transaction-level reference model with a
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
module tb_uart_rx_reader;

    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [7:0]  data;
    logic        valid;
    logic        ready = 1'b0;
    logic        err_overrun;
    logic        err_frame;
    logic        err_parity;
    logic        err_resp;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // slave behaviour controls (-1 latency = random)
    int          ar_lat = 0;
    int          r_lat  = 0;
    bit          fix_en = 1'b1;
    logic [31:0] fix_stat = 32'h0;
    logic [31:0] fix_rx   = 32'h0;
    logic [1:0]  fix_stat_resp = 2'b00;
    logic [1:0]  fix_rx_resp   = 2'b00;

    uart_rx_reader #(.POLL_GAP(POLL_GAP), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .data(data), .valid(valid), .ready(ready),
        .err_overrun(err_overrun), .err_frame(err_frame), .err_parity(err_parity),
        .err_resp(err_resp), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_stat();
        logic [31:0] v;
        v    = $urandom;
        v[0] = ($urandom_range(0, 9) < 6);
        v[5] = ($urandom_range(0, 9) == 0);
        v[6] = ($urandom_range(0, 9) == 0);
        v[7] = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    function automatic logic [1:0] rand_resp();
        if ($urandom_range(0, 19) == 0) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    // ---------------- AXI-Lite slave stub ----------------
    initial begin : slave
        bit         s_arv;
        bit         s_rr;
        bit         pend;
        logic [3:0] s_addr;
        logic [3:0] pend_addr;
        int         ar_cnt;
        int         r_cnt;
        bit         fire;
        s_arv = 0; s_rr = 0; pend = 0; s_addr = 4'h0; pend_addr = 4'h0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            s_arv  = m_arvalid;
            s_addr = m_araddr;
            s_rr   = m_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0; ar_cnt = 0; r_cnt = 0;
                m_arready = 1'b0;
                m_rvalid  = 1'b0;
            end else begin
                if (m_rvalid && s_rr) begin
                    pend = 0;
                    m_rvalid = 1'b0;
                end
                if (s_arv && m_arready) begin
                    pend = 1; pend_addr = s_addr; ar_cnt = 0; r_cnt = 0;
                    m_rvalid = 1'b0;
                end
                if (m_arvalid) begin
                    m_arready = (ar_lat < 0) ? 1'($urandom_range(0, 1)) : (ar_cnt >= ar_lat);
                    ar_cnt++;
                end else begin
                    m_arready = (ar_lat < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    ar_cnt = 0;
                end
                if (!pend) begin
                    // stray R traffic the reader must ignore
                    m_rvalid = (!fix_en) && ($urandom_range(0, 7) == 0);
                    m_rdata  = $urandom;
                    m_rresp  = 2'($urandom_range(0, 3));
                end else if (!m_rvalid) begin
                    fire = (r_lat < 0) ? ($urandom_range(0, 2) == 0) : (r_cnt >= r_lat);
                    if (fire) begin
                        m_rvalid = 1'b1;
                        if (pend_addr == 4'h8) begin
                            m_rdata = fix_en ? fix_stat : rand_stat();
                            m_rresp = fix_en ? fix_stat_resp : rand_resp();
                        end else begin
                            m_rdata = fix_en ? fix_rx : $urandom;
                            m_rresp = fix_en ? fix_rx_resp : rand_resp();
                        end
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- transaction-level reference model + compare ----------------
    typedef enum {P_IDLE, P_REQ, P_WAIT, P_BYTE, P_PAUSE} phase_t;
    phase_t     ph = P_IDLE;
    logic [3:0] req_addr = 4'h8;
    int         pause_left = 0;
    logic [7:0] last_byte = 8'h00;
    logic [3:0] exp_err = 4'h0;   // {resp, parity, frame, overrun}

    always @(negedge clk) begin
        logic [3:0] set_err;
        cyc++;
        if (rst) begin
            check("rst_arvalid", m_arvalid, 0);
            check("rst_araddr", m_araddr, 4'h8);
            check("rst_valid", valid, 0);
            check("rst_data", data, 8'h00);
            check("rst_errs", {err_resp, err_parity, err_frame, err_overrun}, 4'h0);
            ph = P_IDLE; req_addr = 4'h8; last_byte = 8'h00; exp_err = 4'h0;
        end else begin
            check("arvalid", m_arvalid, (ph == P_REQ));
            if (ph == P_REQ) check("araddr", m_araddr, req_addr);
            check("rready", m_rready, (ph == P_WAIT));
            check("valid", valid, (ph == P_BYTE));
            check("data", data, last_byte);
            check("errs", {err_resp, err_parity, err_frame, err_overrun}, exp_err);

            set_err = 4'h0;
            case (ph)
                P_IDLE: if (enable) begin ph = P_REQ; req_addr = 4'h8; end
                P_REQ: if (m_arready) ph = P_WAIT;
                P_WAIT: if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        set_err[3] = 1'b1;
                        ph = P_PAUSE; pause_left = POLL_GAP;
                    end else if (req_addr == 4'h8) begin
                        set_err[2:0] = m_rdata[7:5];
                        if (m_rdata[0]) begin ph = P_REQ; req_addr = 4'h0; end
                        else begin ph = P_PAUSE; pause_left = POLL_GAP; end
                    end else begin
                        ph = P_BYTE; last_byte = m_rdata[7:0];
                    end
                end
                P_BYTE: if (ready) begin
                    ph = enable ? P_REQ : P_IDLE; req_addr = 4'h8;
                end
                P_PAUSE: begin
                    if (pause_left == 1) begin
                        ph = enable ? P_REQ : P_IDLE; req_addr = 4'h8;
                    end else begin
                        pause_left--;
                    end
                end
                default: ph = P_IDLE;
            endcase
            exp_err = set_err | (exp_err & ~{4{err_clr}});
        end
    end

    // ---------------- directed scenarios, then random traffic ----------------
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        bit found;
        bit bad;
        bit saw_valid;
        int cnt;
        int hs1;
        int hs2;

        repeat (3) drive_edge();
        rst = 1'b0;

        // 1: reset while a STAT address is waiting for arready
        ar_lat = 100; r_lat = 0; fix_en = 1; fix_stat = 32'h0; enable = 1'b1;
        repeat (3) drive_edge();
        @(negedge clk);
        check("t1_pre_arvalid", m_arvalid, 1);
        drive_edge();
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("t1_arvalid", m_arvalid, 0);
        check("t1_valid", valid, 0);
        check("t1_errs", {err_resp, err_parity, err_frame, err_overrun}, 4'h0);
        check("t1_araddr", m_araddr, 4'h8);
        drive_edge();
        rst = 1'b0;
        repeat (2) drive_edge();

        // 2: zero-wait pop of 0x41
        ar_lat = 0; r_lat = 0; fix_stat = 32'h1; fix_rx = 32'h41; ready = 1'b1;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_arvalid) found = 1;
        end
        check("t2_first_ar", found, 1);
        found = 0; cnt = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            cnt++;
            if (valid) found = 1;
        end
        check("t2_got_valid", found, 1);
        check("t2_latency", cnt, 4);
        check("t2_data", data, 8'h41);
        @(negedge clk);
        check("t2_valid_one_cycle", valid, 0);
        check("t2_next_arvalid", m_arvalid, 1);
        check("t2_next_araddr", m_araddr, 4'h8);
        drive_edge();
        enable = 1'b0;
        repeat (30) drive_edge();

        // 3: empty STAT polling period
        fix_stat = 32'h0;
        drive_edge();
        enable = 1'b1;
        hs1 = -1; hs2 = -1; saw_valid = 0;
        for (int i = 0; i < 100 && hs2 < 0; i++) begin
            @(negedge clk);
            if (valid) saw_valid = 1;
            if (m_arvalid && m_arready && m_araddr == 4'h8) begin
                if (hs1 < 0) hs1 = i;
                else         hs2 = i;
            end
        end
        check("t3_two_polls", (hs2 >= 0), 1);
        check("t3_poll_period", hs2 - hs1, POLL_GAP + 2);
        check("t3_no_valid", saw_valid, 0);
        drive_edge();
        enable = 1'b0;
        repeat (40) drive_edge();

        // 4: error bits in STAT, consumer stalls 10 cycles
        err_clr = 1'b1;
        drive_edge();
        err_clr = 1'b0;
        fix_stat = 32'hA1; fix_rx = 32'h5A; ready = 1'b0; enable = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (valid) found = 1;
        end
        check("t4_got_valid", found, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (data !== 8'h5A || valid !== 1'b1 || m_arvalid !== 1'b0) bad = 1;
        end
        check("t4_hold_stable", bad, 0);
        check("t4_err_overrun", err_overrun, 1);
        check("t4_err_parity", err_parity, 1);
        check("t4_err_frame", err_frame, 0);
        drive_edge();
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_released", valid, 0);
        check("t4_next_ar", m_arvalid, 1);
        drive_edge();
        enable = 1'b0;
        repeat (60) drive_edge();

        // 5: SLVERR on the RX pop, clear, then clear coincident with a new error
        err_clr = 1'b1;
        drive_edge();
        err_clr = 1'b0;
        fix_stat = 32'h1; fix_rx = 32'h77; fix_rx_resp = 2'b10; enable = 1'b1;
        found = 0; saw_valid = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (valid) saw_valid = 1;
            if (err_resp) found = 1;
        end
        check("t5_err_resp_set", err_resp, 1);
        check("t5_no_valid", saw_valid, 0);
        drive_edge();
        err_clr = 1'b1;
        drive_edge();
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_err_resp_cleared", err_resp, 0);
        drive_edge();
        err_clr = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (err_resp) found = 1;
        end
        check("t5_new_error_wins", err_resp, 1);
        @(negedge clk);
        check("t5_cleared_after", err_resp, 0);
        drive_edge();
        err_clr = 1'b0; enable = 1'b0; fix_rx_resp = 2'b00;
        repeat (60) drive_edge();

        // 6: slow arready, enable dropped while the address waits
        ar_lat = 5; fix_stat = 32'h0;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_arvalid) found = 1;
        end
        check("t6_ar_seen", found, 1);
        drive_edge();
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_arvalid !== 1'b1 || m_araddr !== 4'h8) bad = 1;
        end
        check("t6_ar_stable", bad, 0);
        repeat (30) @(negedge clk);
        check("t6_idle_arvalid", m_arvalid, 0);
        check("t6_idle_rready", m_rready, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_arvalid !== 1'b0) bad = 1;
        end
        check("t6_stays_idle", bad, 0);

        // random traffic
        ar_lat = -1; r_lat = -1; fix_en = 0;
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            drive_edge();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) < 2) rst = 1'b1;
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            ready   = ($urandom_range(0, 9) < 7);
            err_clr = ($urandom_range(0, 99) < 3);
        end
        drive_edge();
        rst = 1'b0; err_clr = 1'b0;
        repeat (5) drive_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
